// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared LSU definitions: funct3 load/store size codes, FSM state encoding, bus widths.
package ysyx_23060332_lsu_pkg;

    localparam int MemAddrBus = 32;
    localparam int MemDataBus = 32;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/ysyx_23060332_lsu_if.sv
// LSU bus bundle: EXU request, data-memory port and WBU response in one interface.
interface ysyx_23060332_lsu_if;
    import ysyx_23060332_lsu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_ren;
    logic                  in_wen;
    logic [2:0]            in_funct3;
    logic [MemAddrBus-1:0] in_addr;
    logic [MemDataBus-1:0] in_wdata;
    logic [4:0]            in_rd;

    logic                  mem_ren;
    logic                  mem_wen;
    logic [MemAddrBus-1:0] mem_raddr;
    logic [MemAddrBus-1:0] mem_waddr;
    logic [MemDataBus-1:0] mem_wdata;
    logic [7:0]            mem_wmask;
    logic [MemDataBus-1:0] mem_rdata;

    logic                  out_valid;
    logic                  out_ready;
    logic [MemDataBus-1:0] out_rdata;
    logic [4:0]            out_rd;
    logic                  out_err;

    modport master (
        output in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
        output mem_rdata, out_ready,
        input  in_ready, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        input  out_valid, out_rdata, out_rd, out_err
    );

    modport slave (
        input  in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
        input  mem_rdata, out_ready,
        output in_ready, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        output out_valid, out_rdata, out_rd, out_err
    );

endinterface

// File: rtl/ysyx_23060332_lsu_align.sv
// Combinational byte-lane logic: store mask/shift and error check on the live request,
// sign/zero extension of the memory read data under the captured funct3.
module ysyx_23060332_lsu_align
    import ysyx_23060332_lsu_pkg::*;
(
    input  logic                  i_ren,
    input  logic                  i_wen,
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_addr_lo,
    input  logic [MemDataBus-1:0] i_wdata,
    input  logic [2:0]            i_ld_funct3,
    input  logic [MemDataBus-1:0] i_rdata,
    output logic [7:0]            o_wmask,
    output logic [MemDataBus-1:0] o_wdata,
    output logic [MemDataBus-1:0] o_rdata,
    output logic                  o_err
);

    logic w_misalign;
    logic w_ld_legal;
    logic w_st_legal;

    always_comb begin
        w_misalign = 1'b0;
        case (i_funct3)
            LSU_H, LSU_HU: w_misalign = i_addr_lo[0];
            LSU_W:         w_misalign = |i_addr_lo;
            default:       w_misalign = 1'b0;
        endcase
    end

    assign w_ld_legal = i_funct3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
    assign w_st_legal = i_funct3 inside {LSU_B, LSU_H, LSU_W};

    // A request with both ren and wen set is handled as a load.
    assign o_err = i_ren ? (~w_ld_legal | w_misalign) :
                   i_wen ? (~w_st_legal | w_misalign) : 1'b0;

    always_comb begin
        o_wmask = 8'h00;
        case (i_funct3)
            LSU_B:   o_wmask = 8'h01 << i_addr_lo;
            LSU_H:   o_wmask = 8'h03 << i_addr_lo;
            LSU_W:   o_wmask = 8'h0F;
            default: o_wmask = 8'h00;
        endcase
    end

    assign o_wdata = i_wdata << {i_addr_lo, 3'b000};

    always_comb begin
        o_rdata = i_rdata;
        case (i_ld_funct3)
            LSU_B:   o_rdata = {{24{i_rdata[7]}}, i_rdata[7:0]};
            LSU_H:   o_rdata = {{16{i_rdata[15]}}, i_rdata[15:0]};
            LSU_BU:  o_rdata = {24'h000000, i_rdata[7:0]};
            LSU_HU:  o_rdata = {16'h0000, i_rdata[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: one request per handshake, LATENCY wait cycles, one-cycle memory strobe,
// result held in RESP until WBU accepts; in_ready only in IDLE (accept->out_valid LATENCY+2, errors 1).
module ysyx_23060332_lsu
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_23060332_lsu_if.slave bus
);

    localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    lsu_state_t            r_state;
    lsu_state_t            w_next;
    logic [3:0]            r_cnt;
    logic [MemAddrBus-1:0] r_addr;
    logic [MemDataBus-1:0] r_wdata;
    logic [7:0]            r_wmask;
    logic [2:0]            r_funct3;
    logic                  r_ren;
    logic                  r_wen;
    logic [4:0]            r_rd;
    logic                  r_err;
    logic [MemDataBus-1:0] r_rdata;

    logic                  w_err;
    logic                  w_mem_op;
    logic                  w_access;
    logic [7:0]            w_wmask;
    logic [MemDataBus-1:0] w_wdata;
    logic [MemDataBus-1:0] w_rdata_ext;

    ysyx_23060332_lsu_align u_align (
        .i_ren       (bus.in_ren),
        .i_wen       (bus.in_wen),
        .i_funct3    (bus.in_funct3),
        .i_addr_lo   (bus.in_addr[1:0]),
        .i_wdata     (bus.in_wdata),
        .i_ld_funct3 (r_funct3),
        .i_rdata     (bus.mem_rdata),
        .o_wmask     (w_wmask),
        .o_wdata     (w_wdata),
        .o_rdata     (w_rdata_ext),
        .o_err       (w_err)
    );

    assign w_mem_op = bus.in_ren | bus.in_wen;
    assign w_access = (r_state == S_ACCESS);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (w_mem_op && !w_err) begin
                        w_next = (LATENCY > 0) ? S_WAIT : S_ACCESS;
                    end else begin
                        w_next = S_RESP;
                    end
                end
            end
            S_WAIT:   if (r_cnt == 4'd0) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   if (bus.out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= 8'h00;
            r_funct3 <= 3'b000;
            r_ren    <= 1'b0;
            r_wen    <= 1'b0;
            r_rd     <= 5'd0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_cnt    <= LAT_M1;
                        r_addr   <= bus.in_addr;
                        r_wdata  <= w_wdata;
                        r_wmask  <= w_wmask;
                        r_funct3 <= bus.in_funct3;
                        r_ren    <= bus.in_ren;
                        r_wen    <= bus.in_wen & ~bus.in_ren;
                        r_rd     <= bus.in_rd;
                        r_err    <= w_err;
                        r_rdata  <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                S_ACCESS: begin
                    if (r_ren) r_rdata <= w_rdata_ext;
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by rst so a reset landing on ACCESS never commits a write.
    assign bus.mem_ren   = w_access & r_ren & ~rst;
    assign bus.mem_wen   = w_access & r_wen & ~rst;
    assign bus.mem_wmask = (w_access & r_wen) ? r_wmask : 8'h00;
    assign bus.mem_raddr = r_addr;
    assign bus.mem_waddr = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_RESP);
    assign bus.out_rdata = r_rdata;
    assign bus.out_rd    = r_rd;
    assign bus.out_err   = r_err;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Bench for ysyx_23060332_lsu: LATENCY=0 and LATENCY=3 instances checked every cycle
// against a transaction-level model of the expected timeline and data.
module tb_ysyx_23060332_lsu;
    import ysyx_23060332_lsu_pkg::*;

    typedef struct packed {
        logic        in_ready;
        logic        mem_ren;
        logic        mem_wen;
        logic [31:0] mem_raddr;
        logic [31:0] mem_waddr;
        logic [31:0] mem_wdata;
        logic [7:0]  mem_wmask;
        logic        out_valid;
        logic [31:0] out_rdata;
        logic [4:0]  out_rd;
        logic        out_err;
    } obs_t;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic        err;
        logic [7:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic        t_valid [2];
    logic        t_ren   [2];
    logic        t_wen   [2];
    logic [2:0]  t_f3    [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [4:0]  t_rd    [2];
    logic [31:0] t_rdata [2];
    logic        t_ready [2];
    obs_t        obs     [2];

    bit   act     [2];
    int   acc_cyc [2];
    exp_t ex      [2];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gd
        ysyx_23060332_lsu_if bus ();
        assign bus.in_valid  = t_valid[g];
        assign bus.in_ren    = t_ren[g];
        assign bus.in_wen    = t_wen[g];
        assign bus.in_funct3 = t_f3[g];
        assign bus.in_addr   = t_addr[g];
        assign bus.in_wdata  = t_wdata[g];
        assign bus.in_rd     = t_rd[g];
        assign bus.mem_rdata = t_rdata[g];
        assign bus.out_ready = t_ready[g];
        assign obs[g] = {bus.in_ready, bus.mem_ren, bus.mem_wen, bus.mem_raddr, bus.mem_waddr,
                         bus.mem_wdata, bus.mem_wmask, bus.out_valid, bus.out_rdata,
                         bus.out_rd, bus.out_err};
        ysyx_23060332_lsu #(.LATENCY(g * 3)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Expected result of one request, from the size/alignment/extension rules.
    function automatic exp_t model(bit ren, bit wen, logic [2:0] f3, logic [31:0] addr,
                                   logic [31:0] wdata, logic [31:0] rdata);
        exp_t   e;
        int     size;
        int     off;
        longint v;
        longint lim;
        e      = '0;
        e.ld   = ren;
        e.st   = wen && !ren;
        e.addr = addr;
        size   = 1 << f3[1:0];
        off    = int'(addr % 4);
        if (e.ld)      e.err = !(f3 inside {0, 1, 2, 4, 5}) || (addr % size != 0);
        else if (e.st) e.err = (f3 > 2) || (addr % size != 0);
        if (e.st && !e.err) begin
            e.mask  = 8'(((1 << size) - 1) << off);
            e.wdata = wdata << (8 * off);
        end
        if (e.ld && !e.err) begin
            lim = 64'sd1 << (8 * size);
            v   = longint'(rdata) % lim;
            if (f3 < 4 && size < 4 && v >= lim / 2) v = v - lim;
            e.rdata = 32'(v);
        end
        return e;
    endfunction

    task automatic check_dut(int d, obs_t o);
        string p;
        int    lat;
        int    acc;
        int    resp;
        bit    mem;
        bit    in_acc;
        p   = (d == 0) ? "L0_" : "L3_";
        lat = d * 3;
        if (rst) begin
            chk({p, "rst_mem_wen"}, 32'(o.mem_wen), 32'd0);
            return;
        end
        if (!act[d]) begin
            chk({p, "idle_in_ready"}, 32'(o.in_ready), 32'd1);
            chk({p, "idle_out_valid"}, 32'(o.out_valid), 32'd0);
            chk({p, "idle_strobes"}, {30'd0, o.mem_ren, o.mem_wen}, 32'd0);
            chk({p, "idle_wmask"}, 32'(o.mem_wmask), 32'd0);
            return;
        end
        mem    = (ex[d].ld || ex[d].st) && !ex[d].err;
        acc    = acc_cyc[d] + lat + 1;
        resp   = mem ? acc + 1 : acc_cyc[d] + 1;
        in_acc = mem && (cyc == acc);
        chk({p, "in_ready"}, 32'(o.in_ready), 32'(cyc == acc_cyc[d]));
        chk({p, "mem_wen"}, 32'(o.mem_wen), 32'(in_acc && ex[d].st));
        chk({p, "mem_ren"}, 32'(o.mem_ren), 32'(in_acc && ex[d].ld));
        if (!(in_acc && ex[d].ld))
            chk({p, "mem_wmask"}, 32'(o.mem_wmask), (in_acc && ex[d].st) ? 32'(ex[d].mask) : 32'd0);
        if (in_acc && ex[d].st) begin
            chk({p, "mem_waddr"}, o.mem_waddr, ex[d].addr);
            chk({p, "mem_wdata"}, o.mem_wdata, ex[d].wdata);
        end
        if (in_acc && ex[d].ld) chk({p, "mem_raddr"}, o.mem_raddr, ex[d].addr);
        chk({p, "out_valid"}, 32'(o.out_valid), 32'(cyc >= resp));
        if (cyc >= resp) begin
            chk({p, "out_rdata"}, o.out_rdata, ex[d].rdata);
            chk({p, "out_err"}, 32'(o.out_err), 32'(ex[d].err));
            chk({p, "out_rd"}, 32'(o.out_rd), 32'(ex[d].rd));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) check_dut(d, obs[d]);
    end

    // Issue one request, keep out_ready low for 'hold' RESP cycles, then accept.
    task automatic txn(int d, bit ren, bit wen, logic [2:0] f3, logic [31:0] addr,
                       logic [31:0] wdata, logic [31:0] rdata, logic [4:0] rd, int hold);
        int resp;
        @(posedge clk); #1;
        ex[d]      = model(ren, wen, f3, addr, wdata, rdata);
        ex[d].rd   = rd;
        t_valid[d] = 1'b1;
        t_ren[d]   = ren;
        t_wen[d]   = wen;
        t_f3[d]    = f3;
        t_addr[d]  = addr;
        t_wdata[d] = wdata;
        t_rd[d]    = rd;
        t_rdata[d] = rdata;
        t_ready[d] = 1'b0;
        act[d]     = 1'b1;
        acc_cyc[d] = cyc;
        resp = ((ren || wen) && !ex[d].err) ? cyc + d * 3 + 2 : cyc + 1;
        @(posedge clk); #1;
        t_valid[d] = 1'b0;
        t_addr[d]  = ~addr;
        t_wdata[d] = ~wdata;
        t_f3[d]    = 3'b111;
        t_rd[d]    = ~rd;
        while (cyc < resp + hold) begin
            @(posedge clk); #1;
        end
        t_ready[d] = 1'b1;
        @(posedge clk); #1;
        t_ready[d] = 1'b0;
        act[d]     = 1'b0;
    endtask

    initial begin
        exp_t m;
        for (int d = 0; d < 2; d++) begin
            t_valid[d] = 1'b0; t_ren[d] = 1'b0; t_wen[d] = 1'b0; t_f3[d] = 3'b000;
            t_addr[d] = '0; t_wdata[d] = '0; t_rd[d] = '0; t_rdata[d] = '0; t_ready[d] = 1'b0;
            act[d] = 1'b0; acc_cyc[d] = 0; ex[d] = '0;
        end

        m = model(1, 0, LSU_B, 32'h80000001, 0, 32'h000000F0);
        chk("pin_lb", m.rdata, 32'hFFFFFFF0);
        m = model(1, 0, LSU_BU, 32'h80000001, 0, 32'h000000F0);
        chk("pin_lbu", m.rdata, 32'h000000F0);
        m = model(1, 0, LSU_H, 32'h80000002, 0, 32'h00008001);
        chk("pin_lh", m.rdata, 32'hFFFF8001);
        m = model(0, 1, LSU_B, 32'h80000003, 32'h000000AB, 0);
        chk("pin_sb_mask", 32'(m.mask), 32'h08);
        chk("pin_sb_wdata", m.wdata, 32'hAB000000);
        m = model(1, 0, LSU_W, 32'h80000002, 0, 0);
        chk("pin_lw_misalign", 32'(m.err), 32'd1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_in_ready", 32'(obs[d].in_ready), 32'd1);
            chk("reset_out_valid", 32'(obs[d].out_valid), 32'd0);
            chk("reset_out_rdata", obs[d].out_rdata, 32'd0);
            chk("reset_out_rd", 32'(obs[d].out_rd), 32'd0);
            chk("reset_out_err", 32'(obs[d].out_err), 32'd0);
            chk("reset_wmask", 32'(obs[d].mem_wmask), 32'd0);
            chk("reset_strobes", {30'd0, obs[d].mem_ren, obs[d].mem_wen}, 32'd0);
        end

        // LATENCY = 0
        txn(0, 0, 1, LSU_W,  32'h80000004, 32'hDEADBEEF, 32'h0,        5'd5,  0);
        txn(0, 0, 1, LSU_B,  32'h80000003, 32'h000000AB, 32'h0,        5'd6,  0);
        txn(0, 0, 1, LSU_H,  32'h80000002, 32'h00001234, 32'h0,        5'd7,  1);
        txn(0, 1, 0, LSU_B,  32'h80000001, 32'h0,        32'h000000F0, 5'd8,  0);
        txn(0, 1, 0, LSU_BU, 32'h80000001, 32'h0,        32'h000000F0, 5'd9,  0);
        txn(0, 1, 0, LSU_H,  32'h80000002, 32'h0,        32'hABCD8001, 5'd10, 0);
        txn(0, 1, 0, LSU_HU, 32'h80000002, 32'h0,        32'hABCD8001, 5'd11, 2);
        txn(0, 1, 0, LSU_W,  32'h80000000, 32'h0,        32'hCAFEF00D, 5'd12, 0);
        txn(0, 1, 0, LSU_W,  32'h80000002, 32'h0,        32'h11111111, 5'd13, 0);
        txn(0, 0, 1, LSU_W,  32'h80000001, 32'h55555555, 32'h0,        5'd14, 0);
        txn(0, 0, 1, LSU_BU, 32'h80000000, 32'h55555555, 32'h0,        5'd15, 0);
        txn(0, 0, 1, 3'b011, 32'h80000000, 32'h55555555, 32'h0,        5'd16, 0);
        txn(0, 1, 0, 3'b110, 32'h80000000, 32'h0,        32'h22222222, 5'd17, 0);
        txn(0, 1, 0, LSU_HU, 32'h80000003, 32'h0,        32'h33333333, 5'd18, 0);
        txn(0, 1, 1, LSU_B,  32'h80000000, 32'h77777777, 32'h00000080, 5'd19, 0);
        txn(0, 0, 0, LSU_W,  32'h80000000, 32'h0,        32'h44444444, 5'd20, 0);

        // LATENCY = 3
        txn(1, 0, 1, LSU_W,  32'h80000004, 32'hDEADBEEF, 32'h0,        5'd21, 4);
        txn(1, 1, 0, LSU_B,  32'h80000003, 32'h0,        32'h0000007F, 5'd22, 0);
        txn(1, 1, 0, LSU_H,  32'h80000006, 32'h0,        32'h0000FFFE, 5'd23, 1);
        txn(1, 1, 0, LSU_W,  32'h80000006, 32'h0,        32'h0,        5'd24, 2);

        // Reset landing on the ACCESS cycle of a store.
        @(posedge clk); #1;
        ex[0]      = model(0, 1, LSU_W, 32'h80000008, 32'h12345678, 32'h0);
        ex[0].rd   = 5'd25;
        t_valid[0] = 1'b1; t_ren[0] = 1'b0; t_wen[0] = 1'b1; t_f3[0] = LSU_W;
        t_addr[0]  = 32'h80000008; t_wdata[0] = 32'h12345678; t_rd[0] = 5'd25;
        act[0]     = 1'b1;
        acc_cyc[0] = cyc;
        @(posedge clk); #1;
        t_valid[0] = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        chk("rst_access_mem_wen", 32'(obs[0].mem_wen), 32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        act[0] = 1'b0;
        @(negedge clk);
        chk("rst_after_in_ready", 32'(obs[0].in_ready), 32'd1);
        chk("rst_after_out_valid", 32'(obs[0].out_valid), 32'd0);
        chk("rst_after_out_rd", 32'(obs[0].out_rd), 32'd0);

        txn(0, 1, 0, LSU_H, 32'h80000002, 32'h0, 32'h00007FFF, 5'd26, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
